dma_data_mover: RTL and testbench
=================================

# dma_data_mover

Downstream stage of the DMA address generator: takes the latched source/destination word addresses plus a word count and moves the data. Reads issue on a req/ack memory read port and land in a small FIFO. The FIFO drains to a req/ack memory write port. A one-cycle `done_o` pulse is raised after the last write is acknowledged.

## Interface
- `ADDR_WIDTH`, 16, word-address width of source, destination and both memory ports
- `DATA_WIDTH`, 32, data word width
- `LEN_WIDTH`, 8, width of the transfer word count
- `FIFO_DEPTH`, 4, staging FIFO entries (power of two, ≥2)

Ports:
- `clk_i`  in  1  single clock; everything samples on the rising edge
- `reset_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  begin transfer; sampled only in IDLE
- `src_addr_i`  in  ADDR_WIDTH  first source word address, captured on accepted start
- `dst_addr_i`  in  ADDR_WIDTH  first destination word address, captured on accepted start
- `len_i`  in  LEN_WIDTH  number of words to move; 0 is a legal empty transfer
- `busy_o`  out  1  high in XFER and DONE
- `done_o`  out  1  one-cycle pulse, high only in the DONE state
- `rd_req_o`  out  1  read request
- `rd_addr_o`  out  ADDR_WIDTH  read word address
- `rd_ack_i`  in  1  read accepted; `rd_data_i` is valid in the same cycle
- `rd_data_i`  in  DATA_WIDTH  read data
- `wr_req_o`  out  1  write request
- `wr_addr_o`  out  ADDR_WIDTH  write word address
- `wr_data_o`  out  DATA_WIDTH  write data (FIFO head)
- `wr_ack_i`  in  1  write accepted

## Operation
- States: IDLE, XFER, DONE.
- IDLE, start with `len_i`≠0:
  - go to XFER.
  - Load `rd_ptr`=`src_addr_i`, `wr_ptr`=`dst_addr_i`.
  - Load `rd_left`=`wr_left`=`len_i`.
- IDLE, start with `len_i`=0: go directly to DONE; no memory traffic.
- `start_i` outside IDLE is ignored and is not queued.
- Read side (XFER only):
  - `rd_req_o`=1 while `rd_left`≠0 and the FIFO is not full.
  - Once asserted, `rd_req_o`, `rd_addr_o` hold stable until `rd_ack_i`.
  - On `rd_ack_i`: push `rd_data_i` into the FIFO, `rd_ptr`+1, `rd_left`−1.
- Write side (XFER only):
  - `wr_req_o`=1 while the FIFO is not empty; `wr_addr_o`=`wr_ptr`, `wr_data_o`=FIFO head.
  - All three hold stable until `wr_ack_i`.
  - On `wr_ack_i`: pop, `wr_ptr`+1, `wr_left`−1.
- XFER→DONE on the edge that samples `wr_ack_i` with `wr_left`=1.
- DONE→IDLE unconditionally after one cycle.
- Address arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF+1 wraps to 0x0000 with no error.
- An ack received while the matching req is low is ignored.
- Push and pop in the same cycle: FIFO count is unchanged, data order is preserved.
- FIFO full: `rd_req_o` deasserts from the next cycle until a pop frees an entry.
- FIFO empty: `wr_req_o`=0.

## Timing
- Reset values (from the cycle after `reset_i` is sampled high):
  - state IDLE, FIFO empty, all pointers and counters 0.
  - `busy_o`, `done_o`, `rd_req_o`, `wr_req_o` = 0.
  - `rd_addr_o`, `wr_addr_o`, `wr_data_o` = 0.
- Reset mid-transfer: abandon the transfer, raise no `done_o`, discard FIFO contents.
- Start accepted at edge 0 ⇒ XFER and `rd_req_o` from cycle 1, `rd_addr_o`=src.
- Zero-wait acks, len=1:
  - read acked in cycle 1.
  - `wr_req_o` in cycle 2, acked in cycle 2.
  - `done_o` in cycle 3.
  - IDLE in cycle 4; a new start is accepted in cycle 4.
- len=0: `done_o` in cycle 1.
- Zero-wait steady state: one word per cycle on each port after the first read. Total latency = len+2 cycles to `done_o`.

## Structure
- Package `dma_pkg`: `dma_state_t` enum (IDLE, XFER, DONE), shared with the address generator's state typedef conventions. Holds default width localparams.
- Sub-module `dma_sync_fifo`:
  - parameterised DATA_WIDTH/DEPTH.
  - ports: push/pop/full/empty/head.
  - same clock and synchronous active-high reset.
- Top: FSM, pointers/counters, port muxing.

## Test plan
- Reset: assert `reset_i` during XFER with 2 words in the FIFO → next cycle all outputs 0, IDLE, no `done_o`. A fresh start then runs cleanly.
- Basic move:
  - src=0x0100, dst=0x0200, len=4, zero-wait acks, mem[0x100..0x103]=A,B,C,D.
  - Expect writes A..D to 0x200..0x203 in order, `done_o` in cycle 6.
- Backpressure:
  - len=8, `wr_ack_i` held low 10 cycles.
  - Expect exactly 4 reads, then `rd_req_o`=0 while full.
  - After acks resume, all 8 words are written in order with `rd_addr_o`/`wr_req` stable while waiting.
- Wrap: src=0xFFFE, dst=0xFFFF, len=3 → reads 0xFFFE,0xFFFF,0x0000; writes 0xFFFF,0x0000,0x0001.
- len=0: start → `done_o` in cycle 1; `rd_req_o`/`wr_req_o` never asserted.
- Start while busy: pulse `start_i` with new values mid-transfer → ignored, original transfer completes unchanged, single `done_o`.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared state encoding and default widths for the DMA data path.
package dma_pkg;

   localparam int DMA_ADDR_WIDTH = 16;
   localparam int DMA_DATA_WIDTH = 32;
   localparam int DMA_LEN_WIDTH  = 8;
   localparam int DMA_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } dma_state_t;

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock staging FIFO between the read and write ports; head is
// presented combinationally so the write port can drive it directly.
module dma_sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DATA_WIDTH-1:0] head_o
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]      wr_idx_q;
   logic [IDX_W-1:0]      rd_idx_q;
   logic [IDX_W:0]        count_q;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_idx_q <= wr_idx_q + IDX_W'(1);
         if (do_pop)  rd_idx_q <= rd_idx_q + IDX_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (IDX_W + 1)'(1);
            2'b01:   count_q <= count_q - (IDX_W + 1)'(1);
            default: ;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; the count gates every
   // read of it, and leaving it reset-free lets it map onto plain RAM/flops.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_idx_q] <= push_data_i;
   end

   assign full_o  = (count_q == (IDX_W + 1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_idx_q];

endmodule

// File: rtl/dma_data_mover.sv
// DMA data mover: streams len words from a source to a destination address
// range through a small FIFO, using req/ack read and write memory ports.
module dma_data_mover
   import dma_pkg::*;
#(
   parameter int ADDR_WIDTH = DMA_ADDR_WIDTH,
   parameter int DATA_WIDTH = DMA_DATA_WIDTH,
   parameter int LEN_WIDTH  = DMA_LEN_WIDTH,
   parameter int FIFO_DEPTH = DMA_FIFO_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] src_addr_i,
   input  logic [ADDR_WIDTH-1:0] dst_addr_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  rd_req_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   input  logic                  rd_ack_i,
   input  logic [DATA_WIDTH-1:0] rd_data_i,
   output logic                  wr_req_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0] wr_data_o,
   input  logic                  wr_ack_i
);

   dma_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LEN_WIDTH-1:0]  rd_left_q, rd_left_d;
   logic [LEN_WIDTH-1:0]  wr_left_q, wr_left_d;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  in_xfer;
   logic                  rd_fire;
   logic                  wr_fire;

   dma_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .push_i      (rd_fire),
      .push_data_i (rd_data_i),
      .pop_i       (wr_fire),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (fifo_head)
   );

   // Requests derive only from registered state, so they stay stable until acked.
   assign in_xfer  = (state_q == XFER);
   assign rd_req_o = in_xfer && (rd_left_q != '0) && !fifo_full;
   assign wr_req_o = in_xfer && !fifo_empty;
   assign rd_fire  = rd_req_o && rd_ack_i;
   assign wr_fire  = wr_req_o && wr_ack_i;

   assign rd_addr_o = rd_ptr_q;
   assign wr_addr_o = wr_ptr_q;
   assign wr_data_o = wr_req_o ? fifo_head : '0;
   assign busy_o    = (state_q != IDLE);
   assign done_o    = (state_q == DONE);

   // NOTE: every next-state signal gets its default first, so no path through
   // the case statement leaves one unassigned and infers a latch.
   always_comb begin
      state_d   = state_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      rd_left_d = rd_left_q;
      wr_left_d = wr_left_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i == '0) begin
                  state_d = DONE;
               end else begin
                  state_d   = XFER;
                  rd_ptr_d  = src_addr_i;
                  wr_ptr_d  = dst_addr_i;
                  rd_left_d = len_i;
                  wr_left_d = len_i;
               end
            end
         end
         XFER: begin
            if (rd_fire) begin
               rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
               rd_left_d = rd_left_q - LEN_WIDTH'(1);
            end
            if (wr_fire) begin
               wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
               wr_left_d = wr_left_q - LEN_WIDTH'(1);
               if (wr_left_q == LEN_WIDTH'(1)) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         rd_left_q <= '0;
         wr_left_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_left_q <= rd_left_d;
         wr_left_q <= wr_left_d;
      end
   end

endmodule

// File: tb/tb_dma_data_mover.sv
// Directed, table-driven bench for dma_data_mover with a behavioural
// source memory and logs of every accepted read and write.
module tb_dma_data_mover;

   localparam int MAXC = 200;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic [15:0] src_addr_i;
   logic [15:0] dst_addr_i;
   logic [7:0]  len_i;
   logic        busy_o;
   logic        done_o;
   logic        rd_req_o;
   logic [15:0] rd_addr_o;
   logic        rd_ack_i;
   logic [31:0] rd_data_i;
   logic        wr_req_o;
   logic [15:0] wr_addr_o;
   logic [31:0] wr_data_o;
   logic        wr_ack_i;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   logic [15:0] rd_log[$];
   logic [47:0] wr_log[$];

   dma_data_mover dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .start_i    (start_i),
      .src_addr_i (src_addr_i),
      .dst_addr_i (dst_addr_i),
      .len_i      (len_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .rd_req_o   (rd_req_o),
      .rd_addr_o  (rd_addr_o),
      .rd_ack_i   (rd_ack_i),
      .rd_data_i  (rd_data_i),
      .wr_req_o   (wr_req_o),
      .wr_addr_o  (wr_addr_o),
      .wr_data_o  (wr_data_o),
      .wr_ack_i   (wr_ack_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {a ^ 16'hC3C3, a};
   endfunction

   assign rd_data_i = mem_word(rd_addr_o);

   // Handshakes are observed at the falling edge, half a cycle before they complete.
   always @(negedge clk_i) begin
      if (rd_req_o && rd_ack_i) rd_log.push_back(rd_addr_o);
      if (wr_req_o && wr_ack_i) wr_log.push_back({wr_addr_o, wr_data_o});
      if (done_o) done_cnt++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic kick(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
      @(posedge clk_i); #1;
      rd_log.delete();
      wr_log.delete();
      done_cnt   = 0;
      src_addr_i = s;
      dst_addr_i = d;
      len_i      = n;
      start_i    = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input bit chk_busy, output int lat);
      lat = -1;
      for (int k = 1; k <= MAXC; k++) begin
         @(negedge clk_i);
         if (k == 1 && chk_busy) check("busy_cycle1", busy_o, 1'b1);
         if (done_o) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) check("done_timeout", 64'(lat), 64'(MAXC));
      #1;
   endtask

   task automatic check_traffic(input string tag, input logic [15:0] s, input logic [15:0] d,
                                input logic [7:0] n);
      logic [15:0] sa, da;
      check({tag, "_nrd"}, 64'(rd_log.size()), 64'(n));
      check({tag, "_nwr"}, 64'(wr_log.size()), 64'(n));
      for (int i = 0; i < int'(n) && i < wr_log.size(); i++) begin
         sa = s + 16'(i);
         da = d + 16'(i);
         check($sformatf("%s_wr%0d", tag, i), wr_log[i], {da, mem_word(sa)});
      end
      for (int i = 0; i < int'(n) && i < rd_log.size(); i++) begin
         sa = s + 16'(i);
         check($sformatf("%s_rd%0d", tag, i), rd_log[i], sa);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy_o, 1'b0);
      check({tag, "_done"}, done_o, 1'b0);
      check({tag, "_rdreq"}, rd_req_o, 1'b0);
      check({tag, "_wrreq"}, wr_req_o, 1'b0);
      check({tag, "_rdaddr"}, rd_addr_o, 16'h0);
      check({tag, "_wraddr"}, wr_addr_o, 16'h0);
      check({tag, "_wrdata"}, wr_data_o, 32'h0);
   endtask

   typedef struct {
      logic [15:0] src;
      logic [15:0] dst;
      logic [7:0]  len;
      int          exp_lat;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int lat;
      bit stable;

      // Latency to done_o is len+2 cycles, or 1 for an empty transfer.
      vecs[0] = '{16'h0100, 16'h0200, 8'd4, 6};
      vecs[1] = '{16'hFFFE, 16'hFFFF, 8'd3, 5};
      vecs[2] = '{16'h0000, 16'h1234, 8'd0, 1};
      vecs[3] = '{16'h0010, 16'h0020, 8'd1, 3};
      vecs[4] = '{16'h0050, 16'h0040, 8'd1, 3};
      vecs[5] = '{16'h1000, 16'h2000, 8'd9, 11};

      reset_i    = 1'b1;
      start_i    = 1'b0;
      src_addr_i = '0;
      dst_addr_i = '0;
      len_i      = '0;
      rd_ack_i   = 1'b1;
      wr_ack_i   = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_idle_outputs("reset");
      @(posedge clk_i); #1;
      reset_i = 1'b0;

      // Acks are held high throughout, so acks without a request are also exercised.
      for (int v = 0; v < 6; v++) begin
         kick(vecs[v].src, vecs[v].dst, vecs[v].len);
         wait_done(1'b1, lat);
         check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
         check($sformatf("v%0d_done_cnt", v), 64'(done_cnt), 64'd1);
         check_traffic($sformatf("v%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len);
      end

      // Backpressure: reads stall 3 cycles, then writes stall 10 cycles.
      rd_ack_i = 1'b0;
      wr_ack_i = 1'b0;
      kick(16'h0A00, 16'h0B00, 8'd8);
      stable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         stable &= rd_req_o && (rd_addr_o == 16'h0A00);
      end
      check("bp_rd_hold", stable, 1'b1);
      @(posedge clk_i); #1;
      rd_ack_i = 1'b1;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i);
         if (k >= 1) stable &= wr_req_o && (wr_addr_o == 16'h0B00) && (wr_data_o == mem_word(16'h0A00));
         if (k >= 4) stable &= !rd_req_o;
      end
      #1;
      check("bp_wr_hold_and_full", stable, 1'b1);
      check("bp_reads_while_full", 64'(rd_log.size()), 64'd4);
      check("bp_rdreq_full", rd_req_o, 1'b0);
      @(posedge clk_i); #1;
      wr_ack_i = 1'b1;
      wait_done(1'b0, lat);
      check("bp_done_cnt", 64'(done_cnt), 64'd1);
      check_traffic("bp", 16'h0A00, 16'h0B00, 8'd8);

      // Start while busy: second request must be dropped.
      kick(16'h0300, 16'h0400, 8'd5);
      @(posedge clk_i); #1;
      src_addr_i = 16'h0700;
      dst_addr_i = 16'h0800;
      len_i      = 8'd2;
      start_i    = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      wait_done(1'b0, lat);
      repeat (4) @(negedge clk_i);
      #1;
      check("busy_start_done_cnt", 64'(done_cnt), 64'd1);
      check_traffic("busy_start", 16'h0300, 16'h0400, 8'd5);
      check("busy_start_idle", busy_o, 1'b0);

      // Reset mid-transfer with two words staged in the FIFO.
      rd_ack_i = 1'b1;
      wr_ack_i = 1'b0;
      kick(16'h0C00, 16'h0D00, 8'd8);
      repeat (2) @(negedge clk_i);
      #1;
      check("mid_reset_staged", 64'(rd_log.size()), 64'd2);
      @(posedge clk_i); #1;
      reset_i = 1'b1;
      @(posedge clk_i); #1;
      reset_i  = 1'b0;
      wr_ack_i = 1'b1;
      @(negedge clk_i);
      check_idle_outputs("mid_reset");
      done_cnt = 0;
      repeat (5) @(negedge clk_i);
      #1;
      check("mid_reset_no_done", 64'(done_cnt), 64'd0);

      kick(16'h0E00, 16'h0F00, 8'd4);
      wait_done(1'b1, lat);
      check("post_reset_latency", 64'(lat), 64'd6);
      check("post_reset_done_cnt", 64'(done_cnt), 64'd1);
      check_traffic("post_reset", 16'h0E00, 16'h0F00, 8'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
